// File: rtl/scm_mc_pkg.sv
// scm_mc_pkg: MD field offsets, control opcodes, address map and window states for scm_mc.
package scm_mc_pkg;
    localparam int MD_TS    = 0;
    localparam int MD_PROTO = 72;
    localparam int MD_MID   = 80;
    localparam int MD_LEN   = 96;
    localparam int MD_DISC  = 108;
    localparam logic [1:0] FL_HEAD = 2'b01;
    localparam logic [1:0] FL_TAIL = 2'b10;
    localparam logic [2:0] OP_WR = 3'b010;
    localparam logic [2:0] OP_RD = 3'b001;
    localparam logic [3:0] OP_RD_RSP = 4'b1011;
    localparam logic [23:0] ADDR_BASE = 24'h700000;
    localparam logic [31:0] ADDR_RST  = 32'h7000_0F00;
    localparam logic [3:0] R_PROTO = 4'd0;
    localparam logic [3:0] R_CTL   = 4'd1;
    localparam logic [3:0] R_RTT   = 4'd2;
    typedef enum logic [1:0] {W_IDLE, W_CNT, W_TAIL, W_DONE} win_t;
endpackage

// File: rtl/scm_mc_ch_stat.sv
// scm_ch_stat: one statistic channel -- protocol match, byte/packet/inter-arrival counters.
module scm_ch_stat #(
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        we_proto,
    input  logic        we_ctl,
    input  logic [7:0]  wdata,
    input  logic        act,
    input  logic [7:0]  proto,
    input  logic [11:0] len,
    input  logic [31:0] ts,
    output logic        hit,
    output logic        disc,
    output logic [63:0] bytes,
    output logic [63:0] pkts,
    output logic [63:0] tsum
);
    logic [7:0] cfg_proto;
    logic en, disc_en, seen;
    logic [31:0] last_ts, dt;
    logic [CNT_W-1:0] b_cnt, p_cnt, t_cnt;

    assign hit = act && en && proto == cfg_proto;
    assign disc = hit && disc_en;
    // the 32-bit difference wraps naturally across timestamp rollover
    assign dt = seen ? ts - last_ts : 32'd0;
    assign bytes = 64'(b_cnt);
    assign pkts = 64'(p_cnt);
    assign tsum = 64'(t_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_proto <= '0;
            en <= 1'b0;
            disc_en <= 1'b0;
        end else begin
            if (we_proto) cfg_proto <= wdata;
            if (we_ctl) {disc_en, en} <= wdata[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_cnt <= '0;
            p_cnt <= '0;
            t_cnt <= '0;
            last_ts <= '0;
            seen <= 1'b0;
        end else if (clr) begin
            b_cnt <= '0;
            p_cnt <= '0;
            t_cnt <= '0;
            last_ts <= '0;
            seen <= 1'b0;
        end else if (hit) begin
            b_cnt <= b_cnt + CNT_W'(len);
            p_cnt <= p_cnt + CNT_W'(1);
            t_cnt <= t_cnt + CNT_W'(dt);
            last_ts <= ts;
            seen <= 1'b1;
        end
    end
endmodule

// File: rtl/scm_mc.sv
// scm_mc: MD/PHV forwarding with NMID rewrite, windowed per-channel statistics
// and control-packet configuration/readout.
module scm_mc
    import scm_mc_pkg::*;
#(
    parameter PLATFORM = "Xilinx",
    parameter logic [7:0] LMID = 8'd7,
    parameter logic [7:0] NMID = 8'd5,
    parameter int CH_NUM = 4,
    parameter int CNT_W = 64,
    parameter logic [7:0] ALF_TH = 8'd250
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [255:0]  in_scm_md,
    input  logic          in_scm_md_wr,
    output logic          out_scm_md_alf,
    input  logic [1023:0] in_scm_phv,
    input  logic          in_scm_phv_wr,
    output logic          out_scm_phv_alf,
    output logic [255:0]  out_scm_md,
    output logic          out_scm_md_wr,
    input  logic          in_scm_md_alf,
    output logic [1023:0] out_scm_phv,
    output logic          out_scm_phv_wr,
    input  logic          in_scm_phv_alf,
    input  logic          gac2scm_sent_start,
    input  logic          gac2scm_sent_end,
    input  logic [133:0]  cin_scm_data,
    input  logic          cin_scm_data_wr,
    output logic          cout_scm_ready,
    output logic [133:0]  cout_scm_data,
    output logic          cout_scm_data_wr,
    input  logic          cin_scm_ready
);
    logic [255:0] md_mem [256];
    logic [1023:0] phv_mem [256];
    logic [7:0] md_wp, md_rp, phv_wp, phv_rp;
    logic [8:0] md_cnt, phv_cnt;
    logic md_push, phv_push, pop;

    assign md_push = in_scm_md_wr && !md_cnt[8];
    assign phv_push = in_scm_phv_wr && !phv_cnt[8];
    assign pop = md_cnt != 9'd0 && phv_cnt != 9'd0 && !in_scm_md_alf && !in_scm_phv_alf;
    assign out_scm_md_alf = in_scm_md_alf || md_cnt > {1'b0, ALF_TH};
    assign out_scm_phv_alf = in_scm_phv_alf || phv_cnt > {1'b0, ALF_TH};

    always_ff @(posedge clk) begin
        if (md_push) md_mem[md_wp] <= in_scm_md;
        if (phv_push) phv_mem[phv_wp] <= in_scm_phv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_wp <= '0;
            md_rp <= '0;
            md_cnt <= '0;
            phv_wp <= '0;
            phv_rp <= '0;
            phv_cnt <= '0;
        end else begin
            md_wp <= md_wp + 8'(md_push);
            md_rp <= md_rp + 8'(pop);
            md_cnt <= md_cnt + 9'(md_push) - 9'(pop);
            phv_wp <= phv_wp + 8'(phv_push);
            phv_rp <= phv_rp + 8'(pop);
            phv_cnt <= phv_cnt + 9'(phv_push) - 9'(pop);
        end
    end

    logic [255:0] md_h, md_o;
    logic [31:0] ts, end_time, n_rtt;
    logic is_l, in_bound, win_ok;
    logic [CH_NUM-1:0] hit, disc;
    win_t win, win_nx;

    assign md_h = md_mem[md_rp];
    assign ts = md_h[MD_TS +: 32];
    assign is_l = md_h[MD_MID +: 8] == LMID;
    assign in_bound = {1'b0, ts} < {1'b0, end_time} + {1'b0, n_rtt};
    assign win_ok = pop && is_l && (win == W_CNT || (win == W_TAIL && in_bound));

    always_comb begin
        md_o = md_h;
        if (is_l) begin
            md_o[MD_MID +: 8] = NMID;
            md_o[MD_DISC] = md_h[MD_DISC] | (|disc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_scm_md <= '0;
            out_scm_phv <= '0;
            out_scm_md_wr <= 1'b0;
            out_scm_phv_wr <= 1'b0;
        end else begin
            out_scm_md_wr <= pop;
            out_scm_phv_wr <= pop;
            if (pop) begin
                out_scm_md <= md_o;
                out_scm_phv <= phv_mem[phv_rp];
            end
        end
    end

    logic acc, wr_h, rd_h, drop, consume, mapped, cfg_we, clr;
    logic [3:0] ch, r;
    logic [31:0] rd_val;
    logic [63:0] vsel;
    logic [63:0] b64 [CH_NUM];
    logic [63:0] p64 [CH_NUM];
    logic [63:0] t64 [CH_NUM];

    assign cout_scm_ready = cin_scm_ready;
    assign acc = cin_scm_data_wr && cin_scm_ready;
    assign ch = cin_scm_data[71:68];
    assign r = cin_scm_data[67:64];
    assign mapped = cin_scm_data[95:72] == ADDR_BASE && ch < 4'(CH_NUM);
    assign wr_h = acc && cin_scm_data[133:132] == FL_HEAD && cin_scm_data[103:96] == LMID
                  && cin_scm_data[126:124] == OP_WR;
    assign rd_h = acc && cin_scm_data[133:132] == FL_HEAD && cin_scm_data[103:96] == LMID
                  && cin_scm_data[126:124] == OP_RD && mapped && r >= 4'd8 && r <= 4'd13;
    // a write packet to this module is swallowed from its head through its tail
    assign consume = acc && (wr_h || drop);
    assign cfg_we = wr_h && mapped;
    assign clr = wr_h && cin_scm_data[95:64] == ADDR_RST && cin_scm_data[0];

    always_comb begin
        vsel = '0;
        for (int c = 0; c < CH_NUM; c++)
            if (ch == 4'(c)) vsel = r[2:1] == 2'b00 ? b64[c] : r[2:1] == 2'b01 ? p64[c] : t64[c];
        rd_val = r[0] ? vsel[63:32] : vsel[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop <= 1'b0;
            n_rtt <= '0;
            cout_scm_data <= '0;
            cout_scm_data_wr <= 1'b0;
        end else begin
            cout_scm_data_wr <= acc && !consume;
            if (acc) drop <= wr_h || (drop && cin_scm_data[133:132] != FL_TAIL);
            if (cfg_we && r == R_RTT) n_rtt <= cin_scm_data[31:0];
            if (acc && !consume)
                cout_scm_data <= rd_h ? {cin_scm_data[133:128], OP_RD_RSP, cin_scm_data[123:112],
                                         cin_scm_data[103:96], cin_scm_data[111:104],
                                         cin_scm_data[95:32], rd_val} : cin_scm_data;
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        scm_ch_stat #(.CNT_W(CNT_W)) u_ch (
            .clk(clk), .rst_n(rst_n), .clr(clr),
            .we_proto(cfg_we && ch == 4'(i) && r == R_PROTO),
            .we_ctl(cfg_we && ch == 4'(i) && r == R_CTL),
            .wdata(cin_scm_data[7:0]), .act(win_ok),
            .proto(md_h[MD_PROTO +: 8]), .len(md_h[MD_LEN +: 12]), .ts(ts),
            .hit(hit[i]), .disc(disc[i]), .bytes(b64[i]), .pkts(p64[i]), .tsum(t64[i])
        );
    end

    always_comb begin
        win_nx = win;
        if (clr) win_nx = W_IDLE;
        else if (win == W_IDLE && gac2scm_sent_start) win_nx = W_CNT;
        else if (win == W_CNT && gac2scm_sent_end) win_nx = W_TAIL;
        else if (win == W_TAIL && pop && is_l && !in_bound) win_nx = W_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= W_IDLE;
            end_time <= '0;
        end else begin
            win <= win_nx;
            if (clr) end_time <= '0;
            else if (win == W_CNT && |hit) end_time <= ts;
        end
    end
endmodule

// File: doc/scm_mc.md
# scm_mc

Multi-channel statistic collection module; a parametrised successor to the single-channel SCM stage. It sits in the MD/PHV pipeline after GME, buffers MD/PHV pairs in FIFOs, forwards them at one pair per cycle with NMID rewrite, and counts bytes, packets and inter-arrival time per channel inside a start/end measurement window. Counters and rules are configured and read over the 134-bit control-packet chain.

## Interface
- PLATFORM, "Xilinx": FIFO IP selection.
- LMID, 8'd7: local module ID, matched at MD[87:80] and control [103:96].
- NMID, 8'd5: next module ID written into MD[87:80].
- CH_NUM, 4: statistic channels, 1..8.
- CNT_W, 64: counter width, 33..64.
- ALF_TH, 8'd250: FIFO used-word almost-full threshold (depth 256).
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_scm_md / in_scm_md_wr  in  256/1  MD from GME.
- out_scm_md_alf  out  1  in_scm_md_alf OR MD usedw > ALF_TH.
- in_scm_phv / in_scm_phv_wr  in  1024/1  PHV from GME.
- out_scm_phv_alf  out  1  in_scm_phv_alf OR PHV usedw > ALF_TH.
- out_scm_md / out_scm_md_wr  out  256/1  MD to next module.
- in_scm_md_alf, in_scm_phv_alf  in  1  downstream backpressure.
- out_scm_phv / out_scm_phv_wr  out  1024/1  PHV to next module.
- gac2scm_sent_start, gac2scm_sent_end  in  1  window start/end pulses.
- cin_scm_data / cin_scm_data_wr  in  134/1  control flits.
- cout_scm_ready  out  1  = cin_scm_ready, combinational.
- cout_scm_data / cout_scm_data_wr  out  134/1  control flits out.
- cin_scm_ready  in  1  downstream control ready.

## Operation
- MD fields: [31:0] timestamp, [79:72] protocol, [87:80] module ID, [107:96] length (bytes), [108] discard.
- Datapath: pop both FIFOs when both non-empty and neither downstream alf high; register out next cycle, wr=1. MD with [87:80]==LMID gets NMID; others bypass untouched.
- Channel i counts an LMID packet when enable[i], protocol==proto[i], window counting. Multiple channels may count the same packet. If any counting channel has discard_en, set MD[108].
- Per channel: bytes += zero-extended length; pkts += 1; time += (ts - last_ts[i]) mod 2^32, +0 on the channel's first packet in the window; last_ts[i] <= ts.
- Window FSM: W_IDLE -(start)-> W_CNT -(end)-> W_TAIL, end_time <= last counted timestamp (any channel). W_TAIL counts while ts < end_time + n_RTT (33-bit compare); first LMID packet with ts >= bound is forwarded uncounted, -> W_DONE. W_DONE: counters frozen, forwarding continues. stat_reset -> W_IDLE from any state. End in W_IDLE ignored; start+end same cycle in W_IDLE -> W_CNT.
- Control flit: [133:132] 01 head, 10 tail; [126:124] 010 write, 001 read; [95:64] address; [31:0] data. Addresses 0x7000_0000 + ch*0x10 + r. Write r=0 proto[7:0], r=1 {discard_en, enable}, r=2 n_RTT (global, any ch). Read r=8..D bytes lo/hi, pkts lo/hi, time lo/hi (upper bits zero when CNT_W<64). 0x7000_0F00 write bit0: stat_reset, one-cycle self-clearing pulse.
- Write to LMID: head and tail consumed (wr=0). Read to LMID mapped: head replaced by {[133:128], 4'b1011, [123:112], [103:96], [111:104], [95:32], value}; tail passes. Unmapped/other dst: pass unchanged. Flits accepted only while cin_scm_ready.
- stat_reset clears counters, last_ts, end_time, first-flags, window FSM; config and FIFOs retained; reset beats a same-cycle count.

## Timing
- Reset: all out_* data 0, all wr 0, FSM W_IDLE, config 0 (all channels disabled).
- MD/PHV: 1 cycle pop-to-output, throughput 1 pair/cycle; MD and PHV wr always coincident.
- Control: 1-cycle latency; counter read reflects values before the same-cycle update.
- Config writes effective next cycle.

## Structure
- Package scm_mc_pkg: MD field offsets, control opcodes, address base/offsets, window state encoding.
- Sub-module scm_ch_stat: one channel's match, counters and last_ts; generated CH_NUM times. FIFOs: existing fifo_256_256 / fifo_1024_256.

## Test plan
- Ch0 proto 0x06 enabled; start; 3 LMID pkts ts 100/150/300, len 64 -> bytes 192, pkts 3, time 200, MD[87:80]=5.
- Ch0 proto 0x06, ch1 proto 0x11, ch1 discard_en; mixed traffic -> separate counts, MD[108]=1 only on proto 0x11.
- n_RTT 50, end after ts 300; pkts ts 320, 360 -> 320 counted, 360 forwarded uncounted, FSM W_DONE.
- Timestamps 0xFFFF_FFF0 then 0x10 -> time +0x20.
- Read 0x7000_000A -> head opcode 1011, MIDs swapped, data=pkts; write 0x7000_0F00 -> counters 0, W_IDLE, proto kept.
- Hold in_scm_md_alf; fill 251 entries -> out_scm_md_alf=1, no output; rst_n low mid-stream -> all outputs 0 immediately.
